uart_tx_fifo: RTL

//   Buffered UART transmitter: bytes are pushed into an internal FIFO and

---
 rtl/uart_tx_fifo.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Buffered UART transmitter. Bytes written through wr_en /
//                wr_data are queued in an internal FIFO and serialized on
//                Rs232_Tx as 8N1 frames (start, 8 data bits LSB first, stop).
//                Defining UART_TX_PARITY_EN inserts an even-parity bit after
//                the data bits (8E1 frames).
//  Ports       : Clk        - system clock, rising edge
//                Rst        - asynchronous reset, active high
//                baud_set   - 0:9600 1:19200 2:38400 3:57600 4:115200,
//                             5-7:9600; sampled once per frame at load
//                wr_en      - push wr_data (ignored while full)
//                wr_data    - byte to transmit
//                full/empty - FIFO occupancy flags
//                fifo_count - bytes queued, excluding the byte on the line
//                Rs232_Tx   - registered serial output, idle high
//                Tx_Done    - one-cycle pulse on the last clock of stop bit
//                busy       - high from frame load to end of stop bit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [2:0]        baud_set,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   fifo_count,
    output logic              Rs232_Tx,
    output logic              Tx_Done,
    output logic              busy
);

    // Bit periods in clocks (integer truncation of CLK_FREQ/baud).
    localparam int c_div_9600   = CLK_FREQ / 9600;
    localparam int c_div_19200  = CLK_FREQ / 19200;
    localparam int c_div_38400  = CLK_FREQ / 38400;
    localparam int c_div_57600  = CLK_FREQ / 57600;
    localparam int c_div_115200 = CLK_FREQ / 115200;
    // The slowest rate has the largest divisor and sizes the counters.
    localparam int c_cnt_w      = $clog2(c_div_9600 + 1);
    localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]    r_wr_ptr;
    logic [ADDR_W-1:0]    r_rd_ptr;
    logic [ADDR_W:0]      r_count;

    logic [7:0]           r_shift;
    logic [7:0]           w_shift_next;
    logic [2:0]           r_bit_idx;
    logic [c_cnt_w-1:0]   r_baud_cnt;
    logic [c_cnt_w-1:0]   r_div;
    logic [c_cnt_w-1:0]   w_div_sel;
    logic                 r_tx;
    logic                 w_tx_next;
    logic                 w_bit_end;
    logic                 w_push;
    logic                 w_pop;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    assign full       = (r_count == c_depth);
    assign empty      = (r_count == '0);
    assign fifo_count = r_count;
    // A write while full is dropped even if a pop happens in the same cycle.
    assign w_push     = wr_en && !full;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define its contents.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Baud divisor selection
    // ------------------------------------------------------------------
    always_comb begin
        w_div_sel = c_cnt_w'(c_div_9600);
        case (baud_set)
            3'd1:    w_div_sel = c_cnt_w'(c_div_19200);
            3'd2:    w_div_sel = c_cnt_w'(c_div_38400);
            3'd3:    w_div_sel = c_cnt_w'(c_div_57600);
            3'd4:    w_div_sel = c_cnt_w'(c_div_115200);
            default: w_div_sel = c_cnt_w'(c_div_9600);
        endcase
    end

    assign w_bit_end = (r_baud_cnt == (r_div - 1'b1));

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        Tx_Done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Looking at the incoming push as well lets a write into an
                // idle, empty FIFO reach LOAD on the very next cycle.
                if (!empty || w_push) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_pop        = 1'b1;
                w_shift_next = r_mem[r_rd_ptr];
                w_state_next = S_START;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    Tx_Done      = 1'b1;
                    w_state_next = empty ? S_IDLE : S_LOAD;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // The line register is loaded with the level of the state being
        // entered, so Rs232_Tx changes exactly on bit boundaries.
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_next = r_parity;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: line register, shifter, bit timing
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_tx       <= 1'b1;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_baud_cnt <= '0;
            r_div      <= c_cnt_w'(c_div_9600);
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_tx    <= w_tx_next;
            r_shift <= w_shift_next;
            if (r_state == S_LOAD) begin
                // Divisor is frozen for the whole frame.
                r_div      <= w_div_sel;
                r_baud_cnt <= '0;
                r_bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
                r_parity   <= ^r_mem[r_rd_ptr];
`endif
            end else if (r_state != S_IDLE) begin
                if (w_bit_end) begin
                    r_baud_cnt <= '0;
                    if (r_state == S_DATA) begin
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                end else begin
                    r_baud_cnt <= r_baud_cnt + 1'b1;
                end
            end
        end
    end

    assign Rs232_Tx = r_tx;
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire
